// File: rtl/ps2_hack_keyboard.sv
// PS/2 set-2 receiver and decoder feeding the Hack keyboard register (0x6000).
// Define HACK_KBD_LOWERCASE_EN to enable Caps Lock and lowercase letters.
module ps2_hack_keyboard #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] hack_scancode,
    output logic       key_strobe,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    logic [1:0]     clk_sync, data_sync;
    logic           filt_clk, fall, fall_data;
    logic [FCW-1:0] filt_cnt;
    rx_state_t      state_q, state_d;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift;
    logic           par_ok, rx_ok, rx_bad;
    logic [TCW-1:0] to_cnt;

    // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            filt_clk  <= 1'b1;
            filt_cnt  <= '0;
            fall      <= 1'b0;
            fall_data <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            fall      <= 1'b0;
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                filt_clk  <= clk_sync[1];
                filt_cnt  <= '0;
                fall      <= ~clk_sync[1];
                fall_data <= data_sync[1];
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        rx_ok   = 1'b0;
        rx_bad  = 1'b0;
        if (state_q != IDLE && !fall && to_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            rx_bad  = 1'b1;
        end else if (fall) begin
            case (state_q)
                IDLE:    if (!fall_data) state_d = DATA;
                DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP: begin
                    state_d = IDLE;
                    if (fall_data && par_ok) rx_ok  = 1'b1;
                    else                     rx_bad = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            par_ok    <= 1'b0;
            to_cnt    <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_valid  <= rx_ok;
            frame_err <= rx_bad;
            if (fall || state_q == IDLE) to_cnt <= '0;
            else                         to_cnt <= to_cnt + 1'b1;
            if (fall) begin
                case (state_q)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shift   <= {fall_data, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY:  par_ok <= ^{shift, fall_data};
                    default: ;
                endcase
            end
            if (rx_ok) rx_byte <= shift;
        end
    end

    // Letters come back uppercase; lower adds 32 to them only.
    function automatic logic [7:0] key_code(input logic ext, input logic [7:0] b,
                                            input logic shifted, input logic lower);
        logic [7:0] c;
        c = 8'd0;
        if (ext) begin
            case (b)
                8'h6B: c = 8'd130; 8'h75: c = 8'd131; 8'h74: c = 8'd132; 8'h72: c = 8'd133;
                8'h6C: c = 8'd134; 8'h69: c = 8'd135; 8'h7D: c = 8'd136; 8'h7A: c = 8'd137;
                8'h70: c = 8'd138; 8'h71: c = 8'd139;
                default: c = 8'd0;
            endcase
        end else begin
            case (b)
                8'h1C: c = "A"; 8'h32: c = "B"; 8'h21: c = "C"; 8'h23: c = "D"; 8'h24: c = "E";
                8'h2B: c = "F"; 8'h34: c = "G"; 8'h33: c = "H"; 8'h43: c = "I"; 8'h3B: c = "J";
                8'h42: c = "K"; 8'h4B: c = "L"; 8'h3A: c = "M"; 8'h31: c = "N"; 8'h44: c = "O";
                8'h4D: c = "P"; 8'h15: c = "Q"; 8'h2D: c = "R"; 8'h1B: c = "S"; 8'h2C: c = "T";
                8'h3C: c = "U"; 8'h2A: c = "V"; 8'h1D: c = "W"; 8'h22: c = "X"; 8'h35: c = "Y";
                8'h1A: c = "Z";
                default: c = 8'd0;
            endcase
            if (c != 8'd0) begin
                if (lower) c = c + 8'd32;
            end else begin
                case (b)
                    8'h16: c = shifted ? "!" : "1";  8'h1E: c = shifted ? "@" : "2";
                    8'h26: c = shifted ? "#" : "3";  8'h25: c = shifted ? "$" : "4";
                    8'h2E: c = shifted ? "%" : "5";  8'h36: c = shifted ? "^" : "6";
                    8'h3D: c = shifted ? "&" : "7";  8'h3E: c = shifted ? "*" : "8";
                    8'h46: c = shifted ? "(" : "9";  8'h45: c = shifted ? ")" : "0";
                    8'h0E: c = shifted ? "~" : 8'd96;  8'h4E: c = shifted ? "_" : "-";
                    8'h55: c = shifted ? "+" : "=";  8'h54: c = shifted ? "{" : "[";
                    8'h5B: c = shifted ? "}" : "]";  8'h5D: c = shifted ? 8'd124 : 8'd92;
                    8'h4C: c = shifted ? ":" : ";";  8'h52: c = shifted ? 8'd34 : 8'd39;
                    8'h41: c = shifted ? "<" : ",";  8'h49: c = shifted ? ">" : ".";
                    8'h4A: c = shifted ? "?" : "/";  8'h29: c = 8'd32;
                    8'h5A: c = 8'd128; 8'h66: c = 8'd129; 8'h76: c = 8'd140;
                    8'h05: c = 8'd141; 8'h06: c = 8'd142; 8'h04: c = 8'd143; 8'h0C: c = 8'd144;
                    8'h03: c = 8'd145; 8'h0B: c = 8'd146; 8'h83: c = 8'd147; 8'h0A: c = 8'd148;
                    8'h01: c = 8'd149; 8'h09: c = 8'd150; 8'h78: c = 8'd151; 8'h07: c = 8'd152;
                    default: c = 8'd0;
                endcase
            end
        end
        return c;
    endfunction

    logic       ext, brk, shift_l, shift_r, shifted, lower_now, lower_alt;
    logic [7:0] make_code, alt_code;

    assign shifted = shift_l | shift_r;
`ifdef HACK_KBD_LOWERCASE_EN
    logic caps;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                           caps <= 1'b0;
        else if (rx_valid && !ext && !brk && rx_byte == 8'h58) caps <= ~caps;
    end
    assign lower_now = ~(shifted ^ caps);
    assign lower_alt = shifted ^ caps;
`else
    assign lower_now = 1'b0;
    assign lower_alt = 1'b0;
`endif
    // A release may arrive with a different shift state than its press, so match both forms.
    assign make_code = key_code(ext, rx_byte, shifted, lower_now);
    assign alt_code  = key_code(ext, rx_byte, ~shifted, lower_alt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext           <= 1'b0;
            brk           <= 1'b0;
            shift_l       <= 1'b0;
            shift_r       <= 1'b0;
            hack_scancode <= '0;
            key_strobe    <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (frame_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == 8'hE0)      ext <= 1'b1;
                else if (rx_byte == 8'hF0) brk <= 1'b1;
                else if (rx_byte != 8'hE1) begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (!ext && rx_byte == 8'h12)      shift_l <= ~brk;
                    else if (!ext && rx_byte == 8'h59) shift_r <= ~brk;
                    else if (make_code != 8'd0) begin
                        if (!brk) begin
                            if (make_code != hack_scancode) begin
                                hack_scancode <= make_code;
                                key_strobe    <= 1'b1;
                            end
                        end else if (hack_scancode != 8'd0 &&
                                     (make_code == hack_scancode || alt_code == hack_scancode)) begin
                            hack_scancode <= 8'd0;
                            key_strobe    <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_hack_keyboard.sv
// Scoreboard bench for ps2_hack_keyboard: PS/2 frames in, rx/error/key events checked in order.
module tb_ps2_hack_keyboard;
    localparam int TO   = 3000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] hack_scancode, rx_byte;
    logic       key_strobe, rx_valid, frame_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       is_err;
        logic [7:0] b;
    } rx_exp_t;

    rx_exp_t    rx_q[$];
    logic [7:0] key_q[$];

    typedef struct {
        logic       ext;
        logic [7:0] code;
        logic [7:0] hack;
    } key_vec_t;

    ps2_hack_keyboard #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .hack_scancode(hack_scancode), .key_strobe(key_strobe),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Monitor: pops expected events as the DUT produces them.
    logic prev_rx_valid = 1'b0;
    initial begin
        rx_exp_t    e;
        logic [7:0] k;
        forever begin
            @(negedge clk);
            if (rx_valid || frame_err) begin
                checks++;
                if (rx_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_event: got valid=%0b err=%0b byte=%h, expected no event",
                             rx_valid, frame_err, rx_byte);
                end else begin
                    e = rx_q.pop_front();
                    if (frame_err !== e.is_err || rx_valid !== !e.is_err ||
                        (!e.is_err && rx_byte !== e.b)) begin
                        errors++;
                        $display("FAIL rx_event: got valid=%0b err=%0b byte=%h, expected err=%0b byte=%h",
                                 rx_valid, frame_err, rx_byte, e.is_err, e.b);
                    end
                end
            end
            if (key_strobe) begin
                checks++;
                if (prev_rx_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL key_latency: key_strobe without rx_valid one cycle earlier");
                end
                checks++;
                if (key_q.size() == 0) begin
                    errors++;
                    $display("FAIL key_event: got strobe with code %0d, expected no strobe", hack_scancode);
                end else begin
                    k = key_q.pop_front();
                    if (hack_scancode !== k) begin
                        errors++;
                        $display("FAIL key_event: got code %0d, expected %0d", hack_scancode, k);
                    end
                end
            end
            prev_rx_valid = rx_valid;
        end
    end

    task automatic send_raw(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        if (bad_par || bad_stop) rx_q.push_back('{is_err: 1'b1, b: 8'h00});
        else                     rx_q.push_back('{is_err: 1'b0, b: b});
        send_raw({~bad_stop, par, b, 1'b0}, 11);
        repeat (2 * HALF) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    task automatic wait_drain(input string name, input int bound);
        for (int i = 0; i < bound && (rx_q.size() != 0 || key_q.size() != 0); i++) @(negedge clk);
        checks++;
        if (rx_q.size() != 0 || key_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d rx and %0d key events outstanding, expected 0",
                     name, rx_q.size(), key_q.size());
        end
    endtask

    task automatic expect_code(input string name, input logic [7:0] exp);
        @(negedge clk);
        checks++;
        if (hack_scancode !== exp) begin
            errors++;
            $display("FAIL %s: hack_scancode got %0d expected %0d", name, hack_scancode, exp);
        end
    endtask

    task automatic expect_all_zero(input string name);
        checks++;
        if (hack_scancode !== 8'd0 || key_strobe !== 1'b0 || rx_byte !== 8'd0 ||
            rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL %s: outputs code=%0d strobe=%0b rx_byte=%h valid=%0b err=%0b, expected all 0",
                     name, hack_scancode, key_strobe, rx_byte, rx_valid, frame_err);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        expect_all_zero("reset_state");
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_make_break();
        key_q.push_back(8'd65);
        send_byte(8'h1C);
        wait_drain("make_a", 200);
        expect_code("make_a_held", 8'd65);
        send_byte(8'hF0);
        key_q.push_back(8'd0);
        send_byte(8'h1C);
        wait_drain("break_a", 200);
        expect_code("break_a_released", 8'd0);
    endtask

    task automatic test_extended();
        send_byte(8'hE0);
        key_q.push_back(8'd131);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        key_q.push_back(8'd0);
        send_byte(8'h75);
        wait_drain("ext_up", 200);
    endtask

    task automatic test_last_wins();
        key_q.push_back(8'd65);
        send_byte(8'h1C);
        key_q.push_back(8'd66);
        send_byte(8'h32);
        send_byte(8'hF0);
        send_byte(8'h1C);
        wait_drain("last_wins", 200);
        expect_code("other_break_keeps", 8'd66);
        send_byte(8'hF0);
        key_q.push_back(8'd0);
        send_byte(8'h32);
        wait_drain("last_wins_release", 200);
    endtask

    task automatic test_shift();
        send_byte(8'h12);
        key_q.push_back(8'd33);
        send_byte(8'h16);
        send_byte(8'hF0);
        send_byte(8'h12);
        key_q.push_back(8'd49);
        send_byte(8'h16);
        send_byte(8'hF0);
        key_q.push_back(8'd0);
        send_byte(8'h16);
        wait_drain("shift", 200);
    endtask

    task automatic test_typematic_and_map();
        key_vec_t kv[10];
        kv = '{'{1'b0, 8'h5A, 8'd128}, '{1'b0, 8'h66, 8'd129}, '{1'b0, 8'h76, 8'd140},
               '{1'b0, 8'h05, 8'd141}, '{1'b0, 8'h07, 8'd152}, '{1'b1, 8'h6B, 8'd130},
               '{1'b1, 8'h71, 8'd139}, '{1'b0, 8'h29, 8'd32},  '{1'b0, 8'h41, 8'd44},
               '{1'b0, 8'h1A, 8'd90}};
        key_q.push_back(8'd65);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h58);
        send_byte(8'hF0);
        key_q.push_back(8'd0);
        send_byte(8'h1C);
        wait_drain("typematic", 200);
        foreach (kv[i]) begin
            if (kv[i].ext) send_byte(8'hE0);
            key_q.push_back(kv[i].hack);
            send_byte(kv[i].code);
            if (kv[i].ext) send_byte(8'hE0);
            send_byte(8'hF0);
            key_q.push_back(8'd0);
            send_byte(kv[i].code);
        end
        wait_drain("map_table", 200);
    endtask

    task automatic test_frame_errors();
        key_q.push_back(8'd32);
        send_byte(8'h29);
        send_frame(8'h1C, 1'b1, 1'b0);
        wait_drain("bad_parity", 200);
        expect_code("bad_parity_keeps", 8'd32);
        send_frame(8'h1C, 1'b0, 1'b1);
        wait_drain("bad_stop", 200);
        expect_code("bad_stop_keeps", 8'd32);
        send_byte(8'hE0);
        send_frame(8'h75, 1'b1, 1'b0);
        send_byte(8'h75);
        send_byte(8'hF0);
        send_frame(8'h29, 1'b0, 1'b1);
        send_byte(8'h29);
        wait_drain("err_clears_flags", 200);
        expect_code("flags_cleared_keeps", 8'd32);
        send_byte(8'hF0);
        key_q.push_back(8'd0);
        send_byte(8'h29);
        wait_drain("err_release", 200);
    endtask

    task automatic test_timeout();
        rx_q.push_back('{is_err: 1'b1, b: 8'h00});
        send_raw(11'b000_1010_1010, 6);
        wait_drain("timeout", TO + 200);
        key_q.push_back(8'd32);
        send_byte(8'h29);
        wait_drain("after_timeout", 200);
        send_byte(8'hF0);
        key_q.push_back(8'd0);
        send_byte(8'h29);
        wait_drain("after_timeout_release", 200);
    endtask

    task automatic test_reset_mid_frame();
        key_q.push_back(8'd65);
        send_byte(8'h1C);
        wait_drain("pre_reset", 200);
        send_raw(11'b110_0011_1000, 4);
        reset_n = 1'b0;
        #1;
        expect_all_zero("reset_mid_frame");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        key_q.push_back(8'd66);
        send_byte(8'h32);
        wait_drain("post_reset", 200);
        send_byte(8'hF0);
        key_q.push_back(8'd0);
        send_byte(8'h32);
        wait_drain("post_reset_release", 200);
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_last_wins();
        test_shift();
        test_typematic_and_map();
        test_frame_errors();
        test_timeout();
        test_reset_mid_frame();
        repeat (10) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
